// File: rtl/nfc_page_buffer.sv
// nfc_page_buffer: single-page buffer shared between host and NAND controller
//   Program path: host fills the page, controller drains it.
//   Read path:    controller fills the page, host drains it.
//   An ownership FSM serialises the two ports over one shared pointer.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   buf_sel/we/re     host port select and strobes, buf_in write data
//   buf_out           host read data (registered, holds when not strobed)
//   cntrl_sel/we/re   controller port select and strobes, cntrl_in write data
//   cntrl_out         controller read data (registered, holds when not strobed)
//   host_buf_status   host-written page complete, ready for controller
//   buf_cntrl_status  controller-written page complete, ready for host
//   buf_err           only with PBUF_ERR_EN: sticky flag for ignored strobes
// Optional feature macro: PBUF_ERR_EN
module nfc_page_buffer #(
    parameter int DataWidth = 16,
    parameter int Depth     = 2048
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 buf_sel,
    input  logic                 buf_we,
    input  logic                 buf_re,
    input  logic [DataWidth-1:0] buf_in,
    output logic [DataWidth-1:0] buf_out,
    input  logic                 cntrl_sel,
    input  logic                 cntrl_we,
    input  logic                 cntrl_re,
    input  logic [DataWidth-1:0] cntrl_in,
    output logic [DataWidth-1:0] cntrl_out,
    output logic                 host_buf_status,
    output logic                 buf_cntrl_status
`ifdef PBUF_ERR_EN
    ,
    output logic                 buf_err
`endif
);
    localparam int AW = $clog2(Depth);

    typedef enum logic [2:0] {IDLE, HOST_WR, CNTRL_RD, CNTRL_WR, HOST_RD} state_t;

    state_t               state, state_nxt;
    logic [DataWidth-1:0] mem [Depth];
    logic [AW-1:0]        ptr;
    logic                 hw, hr, cw, cr;
    logic                 act_hw, act_hr, act_cw, act_cr;
    logic                 last, wr_en, step;
    logic [DataWidth-1:0] wr_data;

    assign hw = buf_sel & buf_we;
    assign hr = buf_sel & buf_re;
    assign cw = cntrl_sel & cntrl_we;
    assign cr = cntrl_sel & cntrl_re;

    // A strobe acts only when it matches the owner/direction of the current
    // state; in IDLE the host write wins over a simultaneous controller write.
    assign act_hw = hw & (state == IDLE || state == HOST_WR);
    assign act_cw = cw & ((state == IDLE && !hw) || state == CNTRL_WR);
    assign act_cr = cr & (state == CNTRL_RD);
    assign act_hr = hr & (state == HOST_RD);

    assign last    = ptr == AW'(Depth - 1);
    assign wr_en   = act_hw | act_cw;
    assign wr_data = act_hw ? buf_in : cntrl_in;
    assign step    = wr_en | act_cr | act_hr;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = act_hw ? HOST_WR : act_cw ? CNTRL_WR : IDLE;
            HOST_WR:  state_nxt = (act_hw && last) ? CNTRL_RD : HOST_WR;
            CNTRL_RD: state_nxt = (act_cr && last) ? IDLE : CNTRL_RD;
            CNTRL_WR: state_nxt = (act_cw && last) ? HOST_RD : CNTRL_WR;
            HOST_RD:  state_nxt = (act_hr && last) ? IDLE : HOST_RD;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            ptr              <= '0;
            buf_out          <= '0;
            cntrl_out        <= '0;
            host_buf_status  <= 1'b0;
            buf_cntrl_status <= 1'b0;
        end else begin
            state <= state_nxt;
            // The last word of every page is the only place the pointer wraps,
            // and it always coincides with a state change.
            if (step)
                ptr <= last ? '0 : ptr + AW'(1);
            if (act_cr)
                cntrl_out <= mem[ptr];
            if (act_hr)
                buf_out <= mem[ptr];
            if (act_hw && last)
                host_buf_status <= 1'b1;
            else if (act_cr && last)
                host_buf_status <= 1'b0;
            if (act_cw && last)
                buf_cntrl_status <= 1'b1;
            else if (act_hr && last)
                buf_cntrl_status <= 1'b0;
        end
    end

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[ptr] <= wr_data;
    end

`ifdef PBUF_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            buf_err <= 1'b0;
        else if ((hw & ~act_hw) | (hr & ~act_hr) | (cw & ~act_cw) | (cr & ~act_cr))
            buf_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_nfc_page_buffer.sv
// tb_nfc_page_buffer: scoreboard bench for nfc_page_buffer
//   The driver pushes the expected output values for the next clock edge into
//   a queue; a monitor pops and compares them shortly after each rising edge.
//   Build with PBUF_ERR_EN to also exercise buf_err.
module tb_nfc_page_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        buf_sel, buf_we, buf_re, cntrl_sel, cntrl_we, cntrl_re;
    logic [15:0] buf_in, cntrl_in, buf_out, cntrl_out;
    logic        host_buf_status, buf_cntrl_status;
`ifdef PBUF_ERR_EN
    logic        buf_err;
`endif

    nfc_page_buffer #(.DataWidth(16), .Depth(2048)) dut (
        .clk(clk), .rst(rst),
        .buf_sel(buf_sel), .buf_we(buf_we), .buf_re(buf_re), .buf_in(buf_in), .buf_out(buf_out),
        .cntrl_sel(cntrl_sel), .cntrl_we(cntrl_we), .cntrl_re(cntrl_re), .cntrl_in(cntrl_in),
        .cntrl_out(cntrl_out), .host_buf_status(host_buf_status), .buf_cntrl_status(buf_cntrl_status)
`ifdef PBUF_ERR_EN
        , .buf_err(buf_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        int          sel;
        logic [15:0] v;
        string       nm;
    } item_t;

    item_t q[$];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // sel: 0 cntrl_out, 1 buf_out, 2 host_buf_status, 3 buf_cntrl_status, 4 buf_err
    always @(posedge clk) begin
        item_t       e;
        logic [15:0] act;
        #3;
        while (q.size() > 0 && q[0].tag <= cyc) begin
            e = q.pop_front();
            case (e.sel)
                0: act = cntrl_out;
                1: act = buf_out;
                2: act = {15'd0, host_buf_status};
                3: act = {15'd0, buf_cntrl_status};
`ifdef PBUF_ERR_EN
                4: act = {15'd0, buf_err};
`endif
                default: act = 16'hxxxx;
            endcase
            checks++;
            if (act !== e.v || e.tag != cyc) begin
                errors++;
                $display("FAIL %s cycle %0d got %h expected %h", e.nm, cyc, act, e.v);
            end
        end
    end

    // Expectation for the outputs right after the next rising edge.
    task automatic chk(input int sel, input logic [15:0] v, input string nm);
        item_t it;
        it.tag = cyc + 1;
        it.sel = sel;
        it.v   = v;
        it.nm  = nm;
        q.push_back(it);
    endtask

    task automatic drv(input logic bs, bw, br, input logic [15:0] bi,
                       input logic cs, cw, cr, input logic [15:0] ci);
        buf_sel = bs; buf_we = bw; buf_re = br; buf_in = bi;
        cntrl_sel = cs; cntrl_we = cw; cntrl_re = cr; cntrl_in = ci;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drv(0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
    endtask

    task automatic host_page(input logic [15:0] base);
        for (int i = 0; i < 2048; i++) begin
            if (i == 2046) chk(2, 16'd0, "hstat_before_last_wr");
            if (i == 2047) chk(2, 16'd1, "hstat_after_last_wr");
            drv(1, 1, 0, 16'(base + i), 0, 0, 0, 16'h0);
        end
    endtask

    task automatic cntrl_read(input logic [15:0] base);
        for (int i = 0; i < 2048; i++) begin
            chk(0, 16'(base + i), "cntrl_rd_data");
            chk(2, (i == 2047) ? 16'd0 : 16'd1, "hstat_during_rd");
            drv(0, 0, 0, 16'h0, 1, 0, 1, 16'h0);
        end
    endtask

    initial begin
        rst = 1'b1;
        buf_sel = 0; buf_we = 0; buf_re = 0; buf_in = 0;
        cntrl_sel = 0; cntrl_we = 0; cntrl_re = 0; cntrl_in = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk(0, 16'h0, "rst_cntrl_out");
        chk(1, 16'h0, "rst_buf_out");
        chk(2, 16'h0, "rst_hstat");
        chk(3, 16'h0, "rst_cstat");
`ifdef PBUF_ERR_EN
        chk(4, 16'h0, "rst_err");
`endif
        idle();

        // Host and controller write together in IDLE: host wins.
`ifdef PBUF_ERR_EN
        chk(4, 16'h1, "err_after_conflict");
`endif
        drv(1, 1, 0, 16'h5000, 1, 1, 0, 16'hDEAD);
        for (int i = 1; i < 100; i++) drv(1, 1, 0, 16'(16'h5000 + i), 0, 0, 0, 16'h0);
        drv(0, 0, 0, 16'h0, 1, 1, 0, 16'hBEEF);
        repeat (5) drv(0, 1, 0, 16'h1111, 0, 0, 0, 16'h0);
        for (int i = 100; i < 2048; i++) begin
            if (i == 2047) chk(2, 16'd1, "pause_hstat_set");
            drv(1, 1, 0, 16'(16'h5000 + i), 0, 0, 0, 16'h0);
        end
        for (int i = 0; i < 2048; i++) begin
            if (i == 1000) begin
                chk(0, 16'h5000 + 16'd999, "hold_on_host_wr_in_rd");
                drv(1, 1, 0, 16'h2222, 0, 0, 0, 16'h0);
            end
            chk(0, 16'(16'h5000 + i), "pause_rd_data");
            if (i == 500) drv(0, 0, 0, 16'h0, 1, 1, 1, 16'hBAD0);
            else drv(0, 0, 0, 16'h0, 1, 0, 1, 16'h0);
        end

        // Plain program path with data = address.
        host_page(16'h0000);
        cntrl_read(16'h0000);

        // Controller read in IDLE after completion is ignored.
        chk(0, 16'd2047, "cntrl_out_hold_idle");
        chk(2, 16'd0, "hstat_idle");
        drv(0, 0, 0, 16'h0, 1, 0, 1, 16'h0);

        // Read path.
        for (int i = 0; i < 2048; i++) begin
            if (i == 2046) chk(3, 16'd0, "cstat_before_last_wr");
            if (i == 2047) chk(3, 16'd1, "cstat_after_last_wr");
            drv(0, 0, 0, 16'h0, 1, 1, 0, 16'(16'hA000 + i));
        end
        for (int i = 0; i < 2048; i++) begin
            chk(1, 16'(16'hA000 + i), "host_rd_data");
            chk(3, (i == 2047) ? 16'd0 : 16'd1, "cstat_during_rd");
            drv(1, 0, 1, 16'h0, 0, 0, 0, 16'h0);
        end
        chk(1, 16'hA7FF, "buf_out_hold_idle");
        drv(1, 0, 1, 16'h0, 0, 0, 0, 16'h0);

        // Reset in the middle of a host page.
        for (int i = 0; i < 1000; i++) drv(1, 1, 0, 16'(16'h3000 + i), 0, 0, 0, 16'h0);
        rst = 1'b1;
        chk(0, 16'h0, "midrst_cntrl_out");
        chk(1, 16'h0, "midrst_buf_out");
        chk(2, 16'h0, "midrst_hstat");
        chk(3, 16'h0, "midrst_cstat");
`ifdef PBUF_ERR_EN
        chk(4, 16'h0, "midrst_err");
`endif
        idle();
        rst = 1'b0;
        idle();
        host_page(16'h7000);
        cntrl_read(16'h7000);

        repeat (3) idle();
        if (q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations got %0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
